// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel row-fetch scheduler.
// Imported by the scheduler top and its position counter.
package gsim_pkg;

  localparam int ROW_W        = 256;
  localparam int ADDR_W       = 10;
  localparam int TAG_W        = 5;
  localparam int ROWS_PER_MAT = 17;
  localparam int OFF_B        = 16;
  localparam int OFF_DIAG     = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/gsim_seq_pos.sv
// Step-able walker over the per-matrix fetch order:
// prologue (16, 0), then NUM_ITER sweeps of offsets 0..15.
module gsim_seq_pos
  import gsim_pkg::*;
#(
  parameter int NUM_ITER = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              step,
  input  logic [TAG_W-1:0]  num_mat,
  output logic [TAG_W-1:0]  mat,
  output logic              pro,
  output logic [TAG_W-1:0]  sweep,
  output logic [TAG_W-1:0]  off,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              fin
);

  localparam logic [TAG_W-1:0] LAST_SW = TAG_W'(NUM_ITER - 1);
  localparam logic [TAG_W-1:0] OB      = TAG_W'(OFF_B);
  localparam logic [TAG_W-1:0] OD      = TAG_W'(OFF_DIAG);
  localparam logic [TAG_W-1:0] O15     = TAG_W'(15);

  logic [TAG_W-1:0] n_mat;
  logic             n_pro;
  logic [TAG_W-1:0] n_sweep;
  logic [TAG_W-1:0] n_off;

  always_comb begin
    n_mat   = mat;
    n_pro   = pro;
    n_sweep = sweep;
    n_off   = off;
    if (clr) begin
      n_mat   = '0;
      n_pro   = 1'b1;
      n_sweep = '0;
      n_off   = OB;
    end else if (step) begin
      unique case (1'b1)
        pro && off == OB: n_off = OD;
        pro && off != OB: n_pro = 1'b0;
        !pro && off != O15: n_off = off + 5'd1;
        !pro && off == O15 && sweep != LAST_SW: begin
          n_sweep = sweep + 5'd1;
          n_off   = '0;
        end
        default: begin
          n_mat   = mat + 5'd1;
          n_pro   = 1'b1;
          n_sweep = '0;
          n_off   = OB;
        end
      endcase
    end
  end

  assign last = !pro && off == O15 && sweep == LAST_SW;
  assign fin  = last && mat == num_mat - 5'd1;

  // Address is registered from the next position so it tracks mat/off exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mat   <= '0;
      pro   <= 1'b0;
      sweep <= '0;
      off   <= '0;
      addr  <= '0;
    end else begin
      mat   <= n_mat;
      pro   <= n_pro;
      sweep <= n_sweep;
      off   <= n_off;
      addr  <= ADDR_W'(n_mat) * ADDR_W'(ROWS_PER_MAT) + ADDR_W'(n_off);
    end
  end

endmodule

// File: rtl/gsim_fetch_sched.sv
// Row-fetch scheduler: credit-limited reads into an in-order row FIFO,
// tagged on the pop side by a second walker over the same order.
module gsim_fetch_sched
  import gsim_pkg::*;
#(
  parameter int NUM_ITER = 16,
  parameter int DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_module_en,
  input  logic [4:0]        i_matrix_num,
  output logic              o_proc_done,
  output logic              o_mem_rreq,
  output logic [9:0]        o_mem_addr,
  input  logic              i_mem_rrdy,
  input  logic [255:0]      i_mem_dout,
  input  logic              i_mem_dout_vld,
  output logic              o_row_vld,
  output logic [255:0]      o_row_data,
  output logic [4:0]        o_row_mat,
  output logic [4:0]        o_row_off,
  output logic [4:0]        o_row_sweep,
  output logic              o_row_pro,
  output logic              o_row_last,
  input  logic              i_row_rdy,
  output logic              o_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  state_t           state;
  state_t           nstate;
  logic [4:0]       n_q;
  logic [CW-1:0]    outst;
  logic [CW-1:0]    occ;
  logic [CW-1:0]    outst_n;
  logic [CW-1:0]    occ_n;
  logic [CW:0]      sum;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [ROW_W-1:0] fifo [DEPTH];
  logic             accept;
  logic             ret;
  logic             pop;
  logic             head;
  logic             start;
  logic             rreq_n;

  logic [4:0]        iss_mat, iss_sweep, iss_off;
  logic              iss_pro, iss_last, iss_fin;
  logic [ADDR_W-1:0] iss_addr;
  logic [4:0]        pop_mat, pop_sweep, pop_off;
  logic              pop_pro, pop_last, pop_fin;
  logic [ADDR_W-1:0] pop_addr;
  logic              unused_pos;

  always_comb begin
    accept = o_mem_rreq & i_mem_rrdy;
    ret    = i_mem_dout_vld && outst != '0;
    head   = occ != '0;
    pop    = head & i_row_rdy;
    start  = state == S_IDLE && i_module_en && i_matrix_num != '0;
    nstate = state;
    unique case (state)
      S_IDLE:
        if (i_module_en) nstate = (i_matrix_num != '0) ? S_RUN : S_DONE;
      S_RUN:   if (accept && iss_fin) nstate = S_DRAIN;
      S_DRAIN: if (pop && pop_fin) nstate = S_DONE;
      S_DONE:  if (!i_module_en) nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
    outst_n = outst + CW'(accept) - CW'(ret);
    occ_n   = occ + CW'(ret) - CW'(pop);
    sum     = (CW+1)'(outst_n) + (CW+1)'(occ_n);
    // Credits count both in-flight and buffered rows, so the FIFO never overflows.
    rreq_n  = nstate == S_RUN && sum < (CW+1)'(DEPTH);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      n_q        <= '0;
      outst      <= '0;
      occ        <= '0;
      wptr       <= '0;
      rptr       <= '0;
      o_mem_rreq <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state      <= nstate;
      outst      <= outst_n;
      occ        <= occ_n;
      o_mem_rreq <= rreq_n;
      if (start) n_q <= i_matrix_num;
      if (ret) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      if (i_mem_dout_vld && outst == '0) o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ret) fifo[wptr] <= i_mem_dout;
  end

  gsim_seq_pos #(.NUM_ITER(NUM_ITER)) u_iss (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .clr     (start),
    .step    (accept),
    .num_mat (n_q),
    .mat     (iss_mat),
    .pro     (iss_pro),
    .sweep   (iss_sweep),
    .off     (iss_off),
    .addr    (iss_addr),
    .last    (iss_last),
    .fin     (iss_fin)
  );

  gsim_seq_pos #(.NUM_ITER(NUM_ITER)) u_pop (
    .clk     (i_clk),
    .reset_n (i_reset_n),
    .clr     (start),
    .step    (pop),
    .num_mat (n_q),
    .mat     (pop_mat),
    .pro     (pop_pro),
    .sweep   (pop_sweep),
    .off     (pop_off),
    .addr    (pop_addr),
    .last    (pop_last),
    .fin     (pop_fin)
  );

  assign unused_pos = ^{iss_mat, iss_pro, iss_sweep, iss_off, iss_last, pop_addr};

  assign o_mem_addr  = iss_addr;
  assign o_proc_done = state == S_DONE;
  assign o_row_vld   = head;
  assign o_row_data  = head ? fifo[rptr] : '0;
  assign o_row_mat   = head ? pop_mat : '0;
  assign o_row_off   = head ? pop_off : '0;
  assign o_row_sweep = head ? pop_sweep : '0;
  assign o_row_pro   = head & pop_pro;
  assign o_row_last  = head & pop_last;

endmodule

// File: tb/tb_gsim_fetch_sched.sv
// Directed bench for gsim_fetch_sched: table of full runs plus
// back-pressure, zero-matrix, unsolicited-return and reset-mid-run cases.
module tb_gsim_fetch_sched;

  localparam int NI = 4;
  localparam int D  = 4;

  logic         clk = 1'b0;
  logic         reset_n, module_en, proc_done;
  logic [4:0]   matrix_num;
  logic         mem_rreq, mem_rrdy, mem_dout_vld;
  logic [9:0]   mem_addr;
  logic [255:0] mem_dout, row_data;
  logic         row_vld, row_pro, row_last, row_rdy, err;
  logic [4:0]   row_mat, row_off, row_sweep;

  always #5 clk = ~clk;

  gsim_fetch_sched #(.NUM_ITER(NI), .DEPTH(D)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_module_en    (module_en),
    .i_matrix_num   (matrix_num),
    .o_proc_done    (proc_done),
    .o_mem_rreq     (mem_rreq),
    .o_mem_addr     (mem_addr),
    .i_mem_rrdy     (mem_rrdy),
    .i_mem_dout     (mem_dout),
    .i_mem_dout_vld (mem_dout_vld),
    .o_row_vld      (row_vld),
    .o_row_data     (row_data),
    .o_row_mat      (row_mat),
    .o_row_off      (row_off),
    .o_row_sweep    (row_sweep),
    .o_row_pro      (row_pro),
    .o_row_last     (row_last),
    .i_row_rdy      (row_rdy),
    .o_err          (err)
  );

  typedef struct {
    logic [4:0] mat;
    logic       pro;
    logic [4:0] sweep;
    logic [4:0] off;
    logic       last;
  } pos_t;

  typedef struct {
    int n;
    bit rr;
    bit rd;
    int reads;
  } vec_t;

  pos_t       expq[$];
  logic [9:0] pend[$];
  logic [9:0] acc[$];
  int total = 0, bad = 0;
  int ki, kp, accepts, pops;
  bit rnd_rrdy, rnd_rdy, hold_rdy, fin_prev, prev_stall;
  logic [9:0] prev_addr;

  function automatic logic [255:0] mkrow(logic [9:0] a);
    return {8{a, 22'h15A5A5}};
  endfunction

  function automatic logic [9:0] paddr(pos_t p);
    return 10'(p.mat) * 10'd17 + 10'(p.off);
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic build(int n);
    pos_t p;
    expq.delete();
    acc.delete();
    ki = 0; kp = 0; accepts = 0; pops = 0;
    fin_prev = 0; prev_stall = 0;
    for (int m = 0; m < n; m++) begin
      p = '{5'(m), 1'b1, 5'd0, 5'd16, 1'b0};
      expq.push_back(p);
      p.off = 5'd0;
      expq.push_back(p);
      for (int s = 0; s < NI; s++)
        for (int o = 0; o < 16; o++) begin
          p = '{5'(m), 1'b0, 5'(s), 5'(o), (s == NI - 1 && o == 15)};
          expq.push_back(p);
        end
    end
  endtask

  // One cycle: observe at negedge, drive inputs for the next posedge.
  task automatic step();
    pos_t e;
    @(negedge clk);
    if (fin_prev) begin
      chk("done_rise", proc_done, 1);
      fin_prev = 0;
    end
    if (prev_stall) begin
      chk("hold_req", mem_rreq, 1);
      chk("hold_addr", mem_addr, prev_addr);
    end
    mem_dout_vld = 1'b0;
    if (pend.size() > 0) begin
      mem_dout_vld = 1'b1;
      mem_dout = mkrow(pend.pop_front());
    end
    mem_rrdy = rnd_rrdy ? 1'($urandom_range(0, 1)) : 1'b1;
    row_rdy  = !hold_rdy && (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    if (mem_rreq && mem_rrdy) begin
      total++;
      if (ki >= expq.size()) begin
        bad++;
        $display("FAIL extra_req: got addr %0d want no request", mem_addr);
      end else if (mem_addr !== paddr(expq[ki])) begin
        bad++;
        $display("FAIL issue_addr: got %0d want %0d", mem_addr, paddr(expq[ki]));
      end
      ki++; accepts++;
      pend.push_back(mem_addr);
      acc.push_back(mem_addr);
    end
    prev_stall = mem_rreq && !mem_rrdy;
    prev_addr  = mem_addr;
    if (row_vld && row_rdy) begin
      if (kp < expq.size()) begin
        e = expq[kp];
        chk("row_data", row_data, mkrow(paddr(e)));
        chk("row_tag", {row_mat, row_off, row_sweep, row_pro, row_last},
            {e.mat, e.off, e.sweep, e.pro, e.last});
        if (kp == expq.size() - 1) begin
          chk("done_early", proc_done, 0);
          fin_prev = 1;
        end
      end else begin
        total++; bad++;
        $display("FAIL extra_pop: got row %0d want none", kp);
      end
      kp++; pops++;
    end
  endtask

  task automatic run(input int n, output int reads, output int npops);
    build(n);
    matrix_num = 5'(n);
    module_en = 1'b1;
    step();
    chk("start_req", mem_rreq, 1);
    chk("start_addr", mem_addr, 16);
    for (int c = 0; c < 4000 && !proc_done; c++) step();
    chk("done", proc_done, 1);
    chk("err_clean", err, 0);
    chk("req_off", mem_rreq, 0);
    reads = accepts;
    npops = pops;
    module_en = 1'b0;
    step();
    chk("done_fall", proc_done, 0);
  endtask

  task automatic chk_zero(string nm);
    chk(nm, {mem_rreq, mem_addr, proc_done, row_vld, row_mat, row_off,
             row_sweep, row_pro, row_last, err}, '0);
    chk({nm, "_data"}, row_data, '0);
  endtask

  vec_t tv[5];
  int r, p;

  initial begin
    tv[0] = '{1, 1'b0, 1'b0, 66};
    tv[1] = '{2, 1'b0, 1'b0, 132};
    tv[2] = '{3, 1'b1, 1'b0, 198};
    tv[3] = '{2, 1'b1, 1'b1, 132};
    tv[4] = '{1, 1'b0, 1'b1, 66};

    reset_n = 1'b0; module_en = 1'b0; matrix_num = '0;
    mem_rrdy = 1'b0; mem_dout_vld = 1'b0; mem_dout = '0; row_rdy = 1'b0;
    rnd_rrdy = 0; rnd_rdy = 0; hold_rdy = 0;
    build(0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    step();

    foreach (tv[i]) begin
      rnd_rrdy = tv[i].rr;
      rnd_rdy  = tv[i].rd;
      run(tv[i].n, r, p);
      chk("reads", r, tv[i].reads);
      chk("pops", p, tv[i].reads);
    end
    rnd_rrdy = 0; rnd_rdy = 0;

    // Consumer stalled: credits cap requests at DEPTH.
    build(2);
    matrix_num = 5'd2;
    module_en = 1'b1;
    hold_rdy = 1;
    repeat (20) step();
    chk("bp_accepts", accepts, D);
    chk("bp_req", mem_rreq, 0);
    chk("bp_vld", row_vld, 1);
    hold_rdy = 0;
    for (int c = 0; c < 2000 && !proc_done; c++) step();
    chk("bp_done", proc_done, 1);
    chk("bp_reads", accepts, 132);
    chk("bp_next_mat", (acc.size() > 66) ? acc[66] : 10'h3FF, 33);
    module_en = 1'b0;
    step();

    // Zero matrices goes straight to done.
    build(0);
    matrix_num = 5'd0;
    module_en = 1'b1;
    step();
    step();
    chk("zero_done", proc_done, 1);
    chk("zero_reads", accepts, 0);
    module_en = 1'b0;
    step();
    chk("zero_idle", proc_done, 0);
    chk("zero_req", mem_rreq, 0);

    // Unsolicited return.
    @(negedge clk);
    mem_dout_vld = 1'b1;
    mem_dout = mkrow(10'd5);
    @(negedge clk);
    mem_dout_vld = 1'b0;
    chk("unsol_err", err, 1);
    chk("unsol_vld", row_vld, 0);
    repeat (3) step();
    chk("unsol_sticky", err, 1);

    // Reset during sweep 3, then restart from the top.
    build(1);
    matrix_num = 5'd1;
    module_en = 1'b1;
    for (int c = 0; c < 500 && kp < 50; c++) step();
    chk("mid_reach", kp >= 50, 1);
    reset_n = 1'b0;
    module_en = 1'b0;
    pend.delete();
    prev_stall = 0;
    fin_prev = 0;
    step();
    chk_zero("mid_reset");
    reset_n = 1'b1;
    step();
    run(1, r, p);
    chk("restart_reads", r, 66);
    chk("restart_first", (acc.size() > 0) ? acc[0] : 10'h3FF, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
